// File: rtl/dual_issue_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction memory port, redirect and decode handshake.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface dual_issue_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_instr1;
    logic [DATA_W-1:0] mem_instr2;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        deq_count;
    logic              out_valid0;
    logic [DATA_W-1:0] out_instr0;
    logic [ADDR_W-1:0] out_pc0;
    logic              out_valid1;
    logic [DATA_W-1:0] out_instr1;
    logic [ADDR_W-1:0] out_pc1;
    logic [CNT_W-1:0]  q_count;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]       perf_stall_cnt;
    logic [15:0]       perf_redirect_cnt;

    modport master (
        output mem_addr, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1, q_count,
               perf_stall_cnt, perf_redirect_cnt,
        input  mem_instr1, mem_instr2, redirect_valid, redirect_pc, deq_count
    );
    modport slave (
        input  mem_addr, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1, q_count,
               perf_stall_cnt, perf_redirect_cnt,
        output mem_instr1, mem_instr2, redirect_valid, redirect_pc, deq_count
    );
`else
    modport master (
        output mem_addr, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1, q_count,
        input  mem_instr1, mem_instr2, redirect_valid, redirect_pc, deq_count
    );
    modport slave (
        input  mem_addr, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1, q_count,
        output mem_instr1, mem_instr2, redirect_valid, redirect_pc, deq_count
    );
`endif
endinterface

// File: rtl/dual_issue_fetch_ctrl.sv
// Dual-issue fetch sequencer: owns the fetch PC, fills an in-order fetch queue in pairs,
// flushes on redirect. Optional saturating perf counters under FETCH_PERF_CNT_EN.
module dual_issue_fetch_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dual_issue_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_q [QDEPTH];
    logic [DATA_W-1:0] instr_d [QDEPTH];
    logic [ADDR_W-1:0] pc_q    [QDEPTH];
    logic [ADDR_W-1:0] pc_d    [QDEPTH];

    logic [1:0]        deq_eff;
    logic [CNT_W-1:0]  deq_ext;
    logic [CNT_W-1:0]  deq_n;
    logic [CNT_W-1:0]  space;
    logic [1:0]        enq_n;
    logic              top_of_mem;
    logic [PTR_W-1:0]  tail_p1;
    logic [PTR_W-1:0]  head_p1;

    assign deq_eff    = (bus.deq_count == 2'd3) ? 2'd2 : bus.deq_count;
    assign deq_ext    = CNT_W'(deq_eff);
    assign deq_n      = (deq_ext > count_q) ? count_q : deq_ext;
    assign space      = CNT_W'(QDEPTH) - count_q;
    assign top_of_mem = (fetch_pc_q == {ADDR_W{1'b1}});
    assign tail_p1    = tail_q + PTR_W'(1);
    assign head_p1    = head_q + PTR_W'(1);

    // Space is judged on the start-of-cycle count so deq_count never reaches mem_addr.
    always_comb begin
        enq_n = 2'd0;
        if (top_of_mem) begin
            if (space >= CNT_W'(1)) enq_n = 2'd1;
        end else begin
            if (space >= CNT_W'(2)) enq_n = 2'd2;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            head_d     = head_q + PTR_W'(deq_n);
            tail_d     = tail_q + PTR_W'(enq_n);
            count_d    = count_q - deq_n + CNT_W'(enq_n);
            fetch_pc_d = fetch_pc_q + ADDR_W'(enq_n);
            if (enq_n != 2'd0) begin
                instr_d[tail_q] = bus.mem_instr1;
                pc_d[tail_q]    = fetch_pc_q;
            end
            if (enq_n == 2'd2) begin
                instr_d[tail_p1] = bus.mem_instr2;
                pc_d[tail_p1]    = fetch_pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    // Invalid slots read as zero so stale flushed entries never leak to decode.
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.q_count    = count_q;
    assign bus.out_valid0 = (count_q >= CNT_W'(1));
    assign bus.out_valid1 = (count_q >= CNT_W'(2));
    assign bus.out_instr0 = bus.out_valid0 ? instr_q[head_q]  : '0;
    assign bus.out_pc0    = bus.out_valid0 ? pc_q[head_q]     : '0;
    assign bus.out_instr1 = bus.out_valid1 ? instr_q[head_p1] : '0;
    assign bus.out_pc1    = bus.out_valid1 ? pc_q[head_p1]    : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [15:0] perf_redirect_cnt_q, perf_redirect_cnt_d;

    always_comb begin
        perf_stall_cnt_d    = perf_stall_cnt_q;
        perf_redirect_cnt_d = perf_redirect_cnt_q;
        if (bus.redirect_valid) begin
            if (perf_redirect_cnt_q != 16'hFFFF) perf_redirect_cnt_d = perf_redirect_cnt_q + 16'd1;
        end else if (enq_n == 2'd0) begin
            if (perf_stall_cnt_q != 16'hFFFF) perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_q    <= '0;
            perf_redirect_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q    <= perf_stall_cnt_d;
            perf_redirect_cnt_q <= perf_redirect_cnt_d;
        end
    end

    assign bus.perf_stall_cnt    = perf_stall_cnt_q;
    assign bus.perf_redirect_cnt = perf_redirect_cnt_q;
`endif
endmodule

// File: tb/tb_dual_issue_fetch_ctrl.sv
// Randomized bench for dual_issue_fetch_ctrl against a queue-based reference model.
// Also checks the perf counters when FETCH_PERF_CNT_EN is defined.
module tb_dual_issue_fetch_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int QD = 4;
    localparam int MSZ = 1 << AW;

    typedef struct {
        logic [DW-1:0] instr;
        int            pc;
    } ent_t;

    logic clk;
    logic rst;
    logic [DW-1:0] mem [MSZ];
    logic [AW-1:0] addr_p1;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mq[$];
    int   mpc;
    int   m_stall;
    int   m_redir;

    dual_issue_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD)) bus ();

    dual_issue_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign addr_p1        = bus.mem_addr + 8'd1;
    assign bus.mem_instr1 = mem[bus.mem_addr];
    assign bus.mem_instr2 = mem[addr_p1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc     = 0;
        m_stall = 0;
        m_redir = 0;
    endtask

    // Reference: redirect flushes; otherwise pop min(deq,size) then append as space allows.
    task automatic model_step(input logic r, input int rpc, input int dq);
        int sz0;
        int n;
        ent_t e;
        if (r) begin
            mq.delete();
            mpc = rpc;
            if (m_redir < 65535) m_redir++;
        end else begin
            sz0 = mq.size();
            n = (dq > 2) ? 2 : dq;
            if (n > sz0) n = sz0;
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (mpc == MSZ - 1 && QD - sz0 >= 1) begin
                e.instr = mem[mpc]; e.pc = mpc; mq.push_back(e);
                mpc = 0;
            end else if (mpc != MSZ - 1 && QD - sz0 >= 2) begin
                e.instr = mem[mpc]; e.pc = mpc; mq.push_back(e);
                e.instr = mem[(mpc + 1) % MSZ]; e.pc = (mpc + 1) % MSZ; mq.push_back(e);
                mpc = (mpc + 2) % MSZ;
            end else begin
                if (m_stall < 65535) m_stall++;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_addr", 64'(bus.mem_addr), 64'(mpc));
        chk("q_count", 64'(bus.q_count), 64'(mq.size()));
        chk("valid0", 64'(bus.out_valid0), 64'(mq.size() >= 1));
        chk("valid1", 64'(bus.out_valid1), 64'(mq.size() >= 2));
        if (mq.size() >= 1) begin
            chk("instr0", 64'(bus.out_instr0), 64'(mq[0].instr));
            chk("pc0", 64'(bus.out_pc0), 64'(mq[0].pc));
        end
        if (mq.size() >= 2) begin
            chk("instr1", 64'(bus.out_instr1), 64'(mq[1].instr));
            chk("pc1", 64'(bus.out_pc1), 64'(mq[1].pc));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", 64'(bus.perf_stall_cnt), 64'(m_stall));
        chk("perf_redir", 64'(bus.perf_redirect_cnt), 64'(m_redir));
`endif
    endtask

    task automatic step(input logic r, input logic [AW-1:0] rpc, input logic [1:0] dq);
        bus.redirect_valid = r;
        bus.redirect_pc    = rpc;
        bus.deq_count      = dq;
        @(posedge clk);
        model_step(r, int'(rpc), int'(dq));
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MSZ; i++) mem[i] = $urandom;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_count      = 2'd0;
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_q_count", 64'(bus.q_count), 64'd0);
        chk("rst_valid0", 64'(bus.out_valid0), 64'd0);
        chk("rst_valid1", 64'(bus.out_valid1), 64'd0);
        chk("rst_instr0", 64'(bus.out_instr0), 64'd0);
        chk("rst_pc1", 64'(bus.out_pc1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // fill with no dequeue
        for (int i = 0; i < 4; i++) step(1'b0, '0, 2'd0);
        chk("fill_qcount", 64'(bus.q_count), 64'd4);
        chk("fill_addr", 64'(bus.mem_addr), 64'd4);
        chk("fill_pc0", 64'(bus.out_pc0), 64'd0);
        chk("fill_pc1", 64'(bus.out_pc1), 64'd1);

        // steady dual dequeue
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 2'd2);
            chk("thru_pc0", 64'(bus.out_pc0), 64'(2 * i + 2));
        end

        // redirect while full with a simultaneous dequeue
        step(1'b1, 8'h30, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 2'd0);
        chk("pre_redir_full", 64'(bus.q_count), 64'd4);
        step(1'b1, 8'h11, 2'd2);
        chk("redir_valid0", 64'(bus.out_valid0), 64'd0);
        chk("redir_qcount", 64'(bus.q_count), 64'd0);
        chk("redir_addr", 64'(bus.mem_addr), 64'h11);
        step(1'b0, '0, 2'd0);
        chk("redir_pc0", 64'(bus.out_pc0), 64'h11);
        chk("redir_pc1", 64'(bus.out_pc1), 64'h12);

        // top-of-memory wrap and over-dequeue
        step(1'b1, 8'hFF, 2'd0);
        step(1'b0, '0, 2'd0);
        chk("top_qcount", 64'(bus.q_count), 64'd1);
        chk("top_pc0", 64'(bus.out_pc0), 64'hFF);
        chk("top_addr", 64'(bus.mem_addr), 64'd0);
        step(1'b0, '0, 2'd3);
        chk("wrap_pc0", 64'(bus.out_pc0), 64'd0);
        chk("wrap_pc1", 64'(bus.out_pc1), 64'd1);

        // single dequeue from empty
        step(1'b1, 8'h00, 2'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 2'd1);
            chk("deq1_max", 64'(bus.q_count <= 3'(QD)), 64'd1);
        end

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 19) == 0), AW'($urandom), 2'($urandom_range(0, 3)));
        end

        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid0", 64'(bus.out_valid0), 64'd0);
        chk("arst_valid1", 64'(bus.out_valid1), 64'd0);
        chk("arst_addr", 64'(bus.mem_addr), 64'd0);
        chk("arst_qcount", 64'(bus.q_count), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_perf_stall", 64'(bus.perf_stall_cnt), 64'd0);
        chk("arst_perf_redir", 64'(bus.perf_redirect_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        check_all();
        step(1'b0, '0, 2'd0);
        chk("restart_pc0", 64'(bus.out_pc0), 64'd0);
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 9) == 0), AW'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dual_issue_fetch_ctrl.md
Name: dual_issue_fetch_ctrl

Overview:
- Fetch sequencer for the dual-issue front end.
- Owns the fetch PC and drives the word address of the dual-issue instruction memory, which returns mem[addr] and mem[addr+1] combinationally.
- Buffers returned instruction pairs in a small in-order fetch queue and presents the two oldest entries to decode.
- Decode consumes 0, 1 or 2 instructions per cycle; the block handles branch/jump redirects by flushing the queue.

Parameters:
- ADDR_W, 8, instruction word-address width (PC width).
- DATA_W, 32, instruction width.
- QDEPTH, 4, fetch queue depth in instructions; power of two, minimum 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_addr  output  ADDR_W  word address to the instruction memory; equals fetch_pc.
- mem_instr1  input  DATA_W  mem[mem_addr], valid in the same cycle.
- mem_instr2  input  DATA_W  mem[mem_addr+1], valid in the same cycle.
- redirect_valid  input  1  taken branch/jump from the back end.
- redirect_pc  input  ADDR_W  redirect target word address.
- deq_count  input  2  instructions consumed by decode this cycle: 0, 1 or 2; value 3 is treated as 2.
- out_valid0  output  1  queue head valid.
- out_instr0  output  DATA_W  head instruction.
- out_pc0  output  ADDR_W  head PC.
- out_valid1  output  1  second entry valid.
- out_instr1  output  DATA_W  second instruction.
- out_pc1  output  ADDR_W  second PC.
- q_count  output  $clog2(QDEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=0, so mem_addr=0.
  - Queue empty, q_count=0, out_valid0=out_valid1=0.
  - out_instr*/out_pc* read 0.
  - Reset takes effect immediately, mid-operation included; all in-flight entries are discarded.
- Outputs are driven from registers only, with no combinational path from deq_count or redirect_* to outputs:
  - out_valid0 = (count>=1).
  - out_valid1 = (count>=2).
  - Slot 0 is always the oldest entry.
- Queue entry = {instr, pc}; circular buffer with head/tail pointers that wrap modulo QDEPTH.
- Per-cycle priority:
  1. Redirect.
  2. Dequeue.
  3. Enqueue.
- Redirect cycle (redirect_valid=1):
  - Queue flushed (count=0); deq_count and the current fetch ignored.
  - fetch_pc <= redirect_pc.
  - Next cycle: outputs invalid, mem_addr=redirect_pc.
  - Target instruction appears at out_*0 two cycles after the redirect cycle.
- Dequeue:
  - n = min(deq_count, count); head advances by n.
  - deq_count greater than count consumes only the valid entries and never underflows.
- Enqueue decision uses the count at the start of the cycle, before dequeue (conservative; avoids a deq_count-to-mem_addr path).
  - Normal pair, when QDEPTH-count>=2 and fetch_pc != max address (2^ADDR_W-1):
    - Write {mem_instr1, fetch_pc} then {mem_instr2, fetch_pc+1}.
    - fetch_pc += 2, modulo 2^ADDR_W.
  - Top-of-memory case, when fetch_pc == 2^ADDR_W-1 and QDEPTH-count>=1:
    - Write only {mem_instr1, fetch_pc}.
    - fetch_pc wraps to 0.
    - mem_instr2 is discarded because mem[addr+1] is out of range.
  - Odd fetch_pc (after a redirect) is legal; pairs are unaligned.
  - Insufficient space: no enqueue, fetch_pc holds, mem_addr stable (fetch stall).
- Count update: count_next = count - n + enq_n, where enq_n is 0, 1 or 2. Never exceeds QDEPTH.
- Simultaneous dequeue and enqueue in the same cycle is allowed; order is preserved.
- Steady state with deq_count=2: throughput 2 instructions per cycle, after 1 cycle of fetch-to-output latency.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt [15:0]: increments every non-redirect cycle in which enqueue was blocked for lack of space.
  - perf_redirect_cnt [15:0]: increments every redirect cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, neither port nor any counter logic exists, and all other behaviour is identical.

Test Plan:
- Release reset, deq_count=0, QDEPTH=4:
  - Cycle 1 enqueues PC 0,1; cycle 2 enqueues PC 2,3.
  - q_count=4, then holds; mem_addr stays 4.
  - out_pc0=0, out_pc1=1.
- After the fill, deq_count=2 every cycle:
  - out_pc0 sequence 0,2,4,6,… with both valids 1 every cycle.
  - Instructions match mem contents.
- deq_count=1 every cycle from empty:
  - out_pc0 sequence 0,1,2,3,… in order with no duplicates or skips.
  - q_count never exceeds 4.
- Queue full, redirect_valid=1, redirect_pc=8'h11, deq_count=2 in the same cycle:
  - Next cycle: out_valid0=0, q_count=0, mem_addr=8'h11.
  - Following cycle: out_pc0=8'h11, out_pc1=8'h12.
- Redirect to 8'hFF:
  - Only PC FF enqueued (q_count=1).
  - Next pair is PC 00, 01.
  - Additionally, with deq_count=3 while count=1: count goes to 0 with no underflow.
- Assert rst=0 asynchronously mid-stream, between clock edges:
  - Outputs go invalid and mem_addr=0 immediately, without waiting for a clock edge.
  - After release, fetch restarts at PC 0.
  - With FETCH_PERF_CNT_EN defined, both counters read 0 after reset.
